// File: rtl/gpr_pkg.sv
// gpr_pkg: shared constants for the GPR bank.
// Holds the power-on rank defaults, the lookup helper and the clear FSM state type.
// Optional feature macro used by the bank: GPR_BYPASS_EN (write-through read forwarding).
package gpr_pkg;

  // Number of entries that carry a non-zero power-on rank value.
  localparam int NUM_RANK_DEFAULTS = 12;

  // Power-on rank values for entries 0..11; every higher entry defaults to zero.
  localparam logic [7:0] RANK_DEFAULTS [NUM_RANK_DEFAULTS] = '{
    8'd12, 8'd8,  8'd8,  8'd8,
    8'd8,  8'd12, 8'd12, 8'd30,
    8'd30, 8'd30, 8'd12, 8'd10
  };

  // Clear sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_e;

  // Default value of entry idx, zero-extended and masked to bw bits.
  function automatic logic [31:0] rank_default(input int idx, input int bw);
    logic [31:0] v;
    v = '0;
    if ((idx >= 0) && (idx < NUM_RANK_DEFAULTS)) begin
      v = {24'd0, RANK_DEFAULTS[4'(idx)]};
    end
    if (bw < 32) begin
      v = v & ((32'd1 << bw) - 32'd1);
    end
    return v;
  endfunction

endpackage

// File: rtl/gpr_clr_fsm.sv
// gpr_clr_fsm: sequential clear engine for gpr_bank.
// Walks the index from 0 to COUNT-1, one entry per cycle, asking the bank to
// restore each entry to its rank default, then pulses done for one cycle.
module gpr_clr_fsm
  import gpr_pkg::*;
#(
  parameter  int COUNT = 32,
  localparam int ADDR  = $clog2(COUNT)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_clr_req,
  output logic            o_clr_busy,
  output logic            o_clr_done,
  output logic            o_clr_wr,
  output logic [ADDR-1:0] o_clr_idx
);

  localparam logic [ADDR-1:0] LAST_IDX = ADDR'(COUNT - 1);

  clr_state_e      r_state;
  clr_state_e      w_state_next;
  logic [ADDR-1:0] r_idx;
  logic [ADDR-1:0] w_idx_next;

  // State and index registers; reset aborts any sequence in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
    end
  end

  // Next-state, index advance and strobes; request is only honoured in IDLE.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    o_clr_busy   = 1'b0;
    o_clr_done   = 1'b0;
    o_clr_wr     = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_clr_req) begin
          w_state_next = CLEAR;
          w_idx_next   = '0;
        end
      end
      CLEAR: begin
        o_clr_busy = 1'b1;
        o_clr_wr   = 1'b1;
        if (r_idx == LAST_IDX) begin
          w_state_next = DONE;
          w_idx_next   = '0;
        end else begin
          w_idx_next = r_idx + 1'b1;
        end
      end
      DONE: begin
        o_clr_done   = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
        w_idx_next   = '0;
      end
    endcase
  end

  assign o_clr_idx = r_idx;

endmodule

// File: rtl/gpr_bank.sv
// gpr_bank: parametrised multi-port GPR bank with pending scoreboard and
// sequential clear engine. Writers are the rank-update datapath, readers the
// arbitration logic. Optional macro GPR_BYPASS_EN adds write-through forwarding
// of same-cycle writes onto the read ports.
module gpr_bank
  import gpr_pkg::*;
#(
  parameter  int BW    = 6,
  parameter  int COUNT = 32,
  parameter  int NWR   = 2,
  parameter  int NRD   = 2,
  localparam int ADDR  = $clog2(COUNT)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NWR-1:0]      we_n,
  input  logic [NWR*ADDR-1:0] w_addr,
  input  logic [NWR*BW-1:0]   w_data,
  input  logic [NRD*ADDR-1:0] r_addr,
  output logic [NRD*BW-1:0]   r_data,
  output logic [NRD-1:0]      r_pend,
  input  logic                rsv_en,
  input  logic [ADDR-1:0]     rsv_addr,
  input  logic                clr_req,
  output logic                clr_busy,
  output logic                clr_done
);

  // Parameter sanity: the rank table needs at least 12 entries and 5-bit values.
  if (BW < 5) begin : g_bw_check
    $error("gpr_bank: BW must be at least 5");
  end
  if (COUNT < 12) begin : g_count_check
    $error("gpr_bank: COUNT must be at least 12");
  end

  // One more bit than an address so COUNT itself is representable.
  localparam logic [ADDR:0] COUNT_L = (ADDR + 1)'(COUNT);

  // Clear engine interface.
  logic            w_clr_busy;
  logic            w_clr_done;
  logic            w_clr_wr;
  logic [ADDR-1:0] w_clr_idx;

  // Write ports after decode: external traffic is dropped while clearing.
  logic [NWR-1:0]  w_wr_en;
  logic [ADDR-1:0] w_wr_addr [NWR];
  logic [BW-1:0]   w_wr_data [NWR];
  logic            w_rsv_act;

  // Storage view shared by all read ports.
  logic [BW-1:0]    w_mem [COUNT];
  logic [COUNT-1:0] w_pend;

  gpr_clr_fsm #(
    .COUNT(COUNT)
  ) u_clr_fsm (
    .clk       (clk),
    .reset     (reset),
    .i_clr_req (clr_req),
    .o_clr_busy(w_clr_busy),
    .o_clr_done(w_clr_done),
    .o_clr_wr  (w_clr_wr),
    .o_clr_idx (w_clr_idx)
  );

  assign clr_busy  = w_clr_busy;
  assign clr_done  = w_clr_done;
  assign w_rsv_act = rsv_en & ~w_clr_busy;

  genvar gi;

  // Unpack write ports; out-of-range addresses never enable a write.
  for (gi = 0; gi < NWR; gi++) begin : g_wr_port
    assign w_wr_addr[gi] = w_addr[gi*ADDR +: ADDR];
    assign w_wr_data[gi] = w_data[gi*BW +: BW];
    assign w_wr_en[gi]   = ~we_n[gi] & ~w_clr_busy &
                           ({1'b0, w_wr_addr[gi]} < COUNT_L);
  end

  // One register plus pending bit per entry, each with its own rank default.
  for (gi = 0; gi < COUNT; gi++) begin : g_entry
    localparam logic [ADDR-1:0] MY_ADDR = ADDR'(gi);
    localparam logic [BW-1:0]   DEF_VAL = BW'(rank_default(gi, BW));

    logic [BW-1:0] r_val;
    logic [BW-1:0] w_val_next;
    logic          r_pend_bit;
    logic          w_pend_next;

    // Next value: clear strobe first, then writes in port order (highest wins),
    // then reserve which overrides the write's pending release.
    always_comb begin
      w_val_next  = r_val;
      w_pend_next = r_pend_bit;
      if (w_clr_wr && (w_clr_idx == MY_ADDR)) begin
        w_val_next  = DEF_VAL;
        w_pend_next = 1'b0;
      end else begin
        for (int k = 0; k < NWR; k++) begin
          if (w_wr_en[k] && (w_wr_addr[k] == MY_ADDR)) begin
            w_val_next  = w_wr_data[k];
            w_pend_next = 1'b0;
          end
        end
        if (w_rsv_act && (rsv_addr == MY_ADDR)) begin
          w_pend_next = 1'b1;
        end
      end
    end

    // Entry state; reset restores the rank default and clears pending.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_val      <= DEF_VAL;
        r_pend_bit <= 1'b0;
      end else begin
        r_val      <= w_val_next;
        r_pend_bit <= w_pend_next;
      end
    end

    assign w_mem[gi]  = r_val;
    assign w_pend[gi] = r_pend_bit;
  end

  // Combinational read ports; out-of-range addresses read as zero, not pending.
  for (gi = 0; gi < NRD; gi++) begin : g_rd_port
    logic [ADDR-1:0] w_ra;
    logic [BW-1:0]   w_rd;
    logic            w_rp;

    assign w_ra = r_addr[gi*ADDR +: ADDR];

    // Stored value, optionally overridden by a same-cycle write to the address.
    always_comb begin
      w_rd = '0;
      w_rp = 1'b0;
      if ({1'b0, w_ra} < COUNT_L) begin
        w_rd = w_mem[w_ra];
        w_rp = w_pend[w_ra];
      end
`ifdef GPR_BYPASS_EN
      // w_wr_en is already low while clearing, so forwarding stops then too.
      for (int k = 0; k < NWR; k++) begin
        if (w_wr_en[k] && (w_wr_addr[k] == w_ra)) begin
          w_rd = w_wr_data[k];
          w_rp = w_rsv_act && (rsv_addr == w_ra);
        end
      end
`endif
    end

    assign r_data[gi*BW +: BW] = w_rd;
    assign r_pend[gi]          = w_rp;
  end

endmodule

// File: doc/gpr_bank.md
Name: gpr_bank

Overview:
Parametrised multi-port general purpose register bank, the successor to the fixed 32x6 two-read/one-write GPR.
- NWR write ports and NRD read ports.
- Per-entry pending scoreboard with a reserve/release handshake.
- Sequential clear engine that restores power-on RANK defaults without a global reset.
- Sits between the rank-update datapath (writers) and the arbitration logic (readers).

Parameters:
BW, 6, entry width in bits; must be >=5 (elaboration-time check, default 30 must fit)
COUNT, 32, number of entries; must be >=12
NWR, 2, number of write ports
NRD, 2, number of read ports
ADDR, $clog2(COUNT), address width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
we_n  in  NWR  per-port write enable, active low
w_addr  in  NWR*ADDR  write addresses, port k at [k*ADDR +: ADDR]
w_data  in  NWR*BW  write data, port k at [k*BW +: BW]
r_addr  in  NRD*ADDR  read addresses
r_data  out  NRD*BW  read data
r_pend  out  NRD  pending bit of each read address
rsv_en  in  1  reserve entry rsv_addr (set pending)
rsv_addr  in  ADDR  entry to reserve
clr_req  in  1  start clear sequence (level sampled)
clr_busy  out  1  clear sequence in progress
clr_done  out  1  one-cycle pulse when clear completes

Behaviour:
- Reset (async): entries 0..11 = {12,8,8,8,8,12,12,30,30,30,12,10}; entries 12..COUNT-1 = 0; all pend = 0; clr_busy = 0; clr_done = 0; internal clear index = 0.
- Writes: synchronous at posedge when we_n[k]=0; visible on r_data the following cycle. Out-of-range address (>=COUNT) is ignored.
- Write collision: several ports target the same address in one cycle -> highest-numbered port wins.
- Reads: combinational, r_data[i] = entry[r_addr[i]]. Out-of-range address returns 0 with r_pend = 0.
- Scoreboard:
  - rsv_en=1 sets pend[rsv_addr] at next edge.
  - Any write to address A clears pend[A] at next edge.
  - Same-cycle reserve and write to the same A -> pend[A] = 1 (reserve wins), data is still written.
  - r_pend[i] = pend[r_addr[i]], combinational.
- Clear FSM:
  - States: IDLE, CLEAR, DONE.
  - IDLE: clr_req=1 -> CLEAR, index=0, clr_busy=1 from next cycle.
  - CLEAR: each cycle writes default(index) to entry[index] and clears pend[index], then index++. After writing index COUNT-1 -> DONE. Occupancy is exactly COUNT cycles.
  - DONE: clr_done=1 and clr_busy=0 for one cycle, then IDLE. clr_req is not sampled in DONE.
  - clr_req while busy is ignored; no queuing.
- While clr_busy=1:
  - All external writes and rsv_en are dropped.
  - Reads stay live and return partially cleared contents.
- Reset asserted mid-clear: aborts immediately to the reset state; clr_done is not pulsed.
- default(idx): table value for idx<12, else 0, zero-extended to BW.

Optional Feature:
GPR_BYPASS_EN
- Defined: write-through forwarding. If r_addr[i] matches an active write port in the same cycle, r_data[i] = that port's w_data (highest port on collision) and r_pend[i] = 0 (or 1 if rsv_en to the same address is also active). Bypass is disabled while clr_busy=1.
- Undefined: reads return the stored pre-edge value and pend bit only.

Decomposition:
- Package gpr_pkg: RANK_DEFAULTS constant array (12 entries), NUM_RANK_DEFAULTS=12, function rank_default(idx, BW), clear FSM state enum {IDLE, CLEAR, DONE}.
- Sub-module gpr_clr_fsm: owns state, index counter, clr_busy/clr_done, and emits a clear write strobe plus index to gpr_bank. Storage, write arbitration and scoreboard stay in gpr_bank.

Test Plan:
- Reset, then read addr 7 and addr 20 -> r_data = 30 and 0; all r_pend = 0.
- Port0 writes addr 5=33 and port1 writes addr 5=17 in the same cycle -> next cycle r_data(addr 5) = 17.
- rsv_en addr 3 -> r_pend = 1 next cycle. Write addr 3=9 while rsv_en addr 3 again -> r_pend stays 1, data = 9. Plain write addr 3=4 -> r_pend = 0.
- Write addr 0=63 and addr 15=5, pulse clr_req -> clr_busy high for 32 cycles, clr_done pulses once; addr 0 = 12, addr 15 = 0. A write issued during busy is lost.
- Assert reset at clear index 10 -> clr_busy = 0 immediately, no clr_done, table restored.
- With GPR_BYPASS_EN: write addr 9=21 while reading addr 9 -> r_data = 21 same cycle. Without the macro -> r_data = 30, then 21 next cycle.
